// File: rtl/membus_arbiter_if.sv
// Client request/grant and memory bus signals shared by membus_arbiter and its users.
interface membus_arbiter_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLIENTS = 2
);
  logic [NUM_CLIENTS-1:0]            c_req;
  logic [NUM_CLIENTS-1:0]            c_we;
  logic [NUM_CLIENTS-1:0]            c_lock;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_wdata;
  logic [NUM_CLIENTS-1:0]            c_gnt;
  logic [NUM_CLIENTS-1:0]            c_rvalid;
  logic [DATA_WIDTH-1:0]             c_rdata;
  logic [ADDR_WIDTH-1:0]             m_addr;
  logic [DATA_WIDTH-1:0]             m_wdata;
  logic                              m_we;
  logic [DATA_WIDTH-1:0]             m_rdata;

  // Clients and the memory device together form the master side.
  modport master (
    output c_req, c_we, c_lock, c_addr, c_wdata, m_rdata,
    input  c_gnt, c_rvalid, c_rdata, m_addr, m_wdata, m_we
  );

  modport slave (
    input  c_req, c_we, c_lock, c_addr, c_wdata, m_rdata,
    output c_gnt, c_rvalid, c_rdata, m_addr, m_wdata, m_we
  );
endinterface

// File: rtl/membus_arbiter.sv
// Round-robin arbiter with per-client burst lock between several clients and one
// synchronous memory port; read data is routed back to the issuing client.
module membus_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CLIENTS  = 2,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  membus_arbiter_if.slave  bus
);
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int PD = READ_LATENCY + 1;

  typedef enum logic {S_OPEN, S_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic                    m_we_q, m_we_d;
  logic [PD-1:0]           pv_q, pv_d;
  logic [IW-1:0]           pid_q [PD];
  logic [IW-1:0]           pid_d [PD];

  logic [NUM_CLIENTS-1:0]  gnt;
  logic [NUM_CLIENTS-1:0]  rvalid;
  logic                    accept;
  logic [IW-1:0]           gidx;
  logic [IW-1:0]           cidx;
  int unsigned             cand;

  // Grant search: ptr, ptr+1, ... with explicit wrap so any client count works.
  always_comb begin
    gnt    = '0;
    accept = 1'b0;
    gidx   = '0;
    cand   = 0;
    cidx   = '0;
    if (!rst) begin
      if (state_q == S_LOCKED) begin
        if (bus.c_req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          accept       = 1'b1;
          gidx         = owner_q;
        end
      end else begin
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
          cand = int'(ptr_q) + k;
          if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
          cidx = IW'(cand);
          if (!accept && bus.c_req[cidx]) begin
            gnt[cidx] = 1'b1;
            accept    = 1'b1;
            gidx      = cidx;
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = 1'b0;
    pv_d      = {pv_q[PD-2:0], 1'b0};
    pid_d[0]  = gidx;
    for (int unsigned j = 1; j < PD; j++) pid_d[j] = pid_q[j-1];
    if (accept) begin
      ptr_d     = (gidx == IW'(NUM_CLIENTS - 1)) ? '0 : gidx + IW'(1);
      m_addr_d  = bus.c_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      m_wdata_d = bus.c_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
      m_we_d    = bus.c_we[gidx];
      pv_d[0]   = ~bus.c_we[gidx];
      if (bus.c_lock[gidx]) begin
        state_d = S_LOCKED;
        owner_d = gidx;
      end else begin
        state_d = S_OPEN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OPEN;
      ptr_q     <= '0;
      owner_q   <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_we_q    <= 1'b0;
      pv_q      <= '0;
      for (int unsigned j = 0; j < PD; j++) pid_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
      pv_q      <= pv_d;
      for (int unsigned j = 0; j < PD; j++) pid_q[j] <= pid_d[j];
    end
  end

  always_comb begin
    rvalid = '0;
    if (pv_q[PD-1]) rvalid[pid_q[PD-1]] = 1'b1;
  end

  assign bus.c_gnt    = gnt;
  assign bus.c_rvalid = rvalid;
  assign bus.c_rdata  = bus.m_rdata;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_we     = m_we_q;
endmodule
